// File: rtl/dual_cnt_dn_if.sv
// Enable/count bundle between the traffic-light controller (master) and
// the dual countdown timer (slave).
interface dual_cnt_dn_if;
    logic       g1_en;
    logic       g2_en;
    logic [7:0] g1_cnt;
    logic [7:0] g2_cnt;
    logic       clk_cnt_dn;
    logic       tick_1s;
    logic       g1_done;
    logic       g2_done;

    modport master (
        output g1_en, g2_en,
        input  g1_cnt, g2_cnt, clk_cnt_dn, tick_1s, g1_done, g2_done
    );

    modport slave (
        input  g1_en, g2_en,
        output g1_cnt, g2_cnt, clk_cnt_dn, tick_1s, g1_done, g2_done
    );
endinterface

// File: rtl/dual_cnt_dn.sv
// Countdown-timer companion to the two-road traffic-light controller: one shared
// 1 s prescaler, a 1 Hz blink wave and two saturating 8-bit seconds counters.
module dual_cnt_dn #(
    parameter int         DIV  = 1000,
    parameter logic [7:0] LOAD = 8'd28
) (
    input  logic         clk_fst,
    input  logic         rst_n,
    dual_cnt_dn_if.slave bus
);

    localparam int             PW       = $clog2(DIV);
    localparam logic [PW-1:0]  PRE_MAX  = PW'(DIV - 1);
    localparam logic [PW-1:0]  PRE_HALF = PW'(DIV / 2 - 1);

    logic [PW-1:0] pre;
    logic          wrap;
    logic          blink_q;
    logic          tick_q;
    logic [7:0]    g1_cnt_q;
    logic [7:0]    g2_cnt_q;
    logic [7:0]    g1_next;
    logic [7:0]    g2_next;
    logic          g1_done_q;
    logic          g2_done_q;

    assign wrap = (pre == PRE_MAX);

    // Free-running prescaler; the blink wave toggles at mid-second and at wrap.
    always_ff @(posedge clk_fst or negedge rst_n) begin
        if (!rst_n) begin
            pre     <= '0;
            blink_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            pre     <= wrap ? '0 : pre + PW'(1);
            tick_q  <= wrap;
            if (wrap || (pre == PRE_HALF)) begin
                blink_q <= ~blink_q;
            end
        end
    end

    // A low enable reloads before anything else, so an enable falling on a wrap edge reloads.
    always_comb begin
        g1_next = g1_cnt_q;
        g2_next = g2_cnt_q;
        if (!bus.g1_en) begin
            g1_next = LOAD;
        end else if (wrap && (g1_cnt_q != 8'd0)) begin
            g1_next = g1_cnt_q - 8'd1;
        end
        if (!bus.g2_en) begin
            g2_next = LOAD;
        end else if (wrap && (g2_cnt_q != 8'd0)) begin
            g2_next = g2_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk_fst or negedge rst_n) begin
        if (!rst_n) begin
            g1_cnt_q  <= LOAD;
            g2_cnt_q  <= LOAD;
            g1_done_q <= 1'b0;
            g2_done_q <= 1'b0;
        end else begin
            g1_cnt_q  <= g1_next;
            g2_cnt_q  <= g2_next;
            g1_done_q <= bus.g1_en && (g1_next == 8'd0);
            g2_done_q <= bus.g2_en && (g2_next == 8'd0);
        end
    end

    assign bus.g1_cnt     = g1_cnt_q;
    assign bus.g2_cnt     = g2_cnt_q;
    assign bus.clk_cnt_dn = blink_q;
    assign bus.tick_1s    = tick_q;
    assign bus.g1_done    = g1_done_q;
    assign bus.g2_done    = g2_done_q;

endmodule
